tmem_crossbar_ctrl: RTL and testbench



---
 rtl/tmem_crossbar_ctrl_pkg.sv | 19 +
 rtl/tmem_crossbar_ctrl_rr_arbiter.sv | 51 +++++
 rtl/tmem_crossbar_ctrl.sv | 119 +++++++++++
 tb/tb_tmem_crossbar_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmem_crossbar_ctrl_pkg.sv
// TMEM crossbar shared constants, bank FSM encoding and helpers.
// Imported by the arbiter and the crossbar top.
package tmem_crossbar_ctrl_pkg;

  localparam int MAX_CORES      = 4;
  localparam int MAX_TMEM_BANKS = 4;
  localparam int WB_WIDTH       = 32;

  typedef enum logic [1:0] {
    TMEM_XB_IDLE  = 2'd0,
    TMEM_XB_ISSUE = 2'd1,
    TMEM_XB_DATA  = 2'd2
  } tmem_xb_state_e;

  function automatic int next_core(input int c, input int n);
    return (c + 1 == n) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/tmem_crossbar_ctrl_rr_arbiter.sv
// Per-bank round-robin arbiter: masked request vector, priority pointer.
// Ports: clk/rst, req_i, mask_i, take_i (advance pointer), any_o/idx_o/oh_o.
import tmem_crossbar_ctrl_pkg::*;

module tmem_rr_arbiter #(
  parameter int N  = MAX_CORES,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic          take_i,
  output logic          any_o,
  output logic [CW-1:0] idx_o,
  output logic [N-1:0]  oh_o
);

  logic [N-1:0]  req_m;
  logic [CW-1:0] ptr_q, ptr_d;

  // Scan from the pointer upward, wrapping; first live request wins.
  always_comb begin
    int j;
    j     = 0;
    req_m = req_i & ~mask_i;
    any_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      if (!any_o && req_m[j]) begin
        any_o = 1'b1;
        idx_o = CW'(j);
      end
    end
    oh_o = '0;
    if (any_o) oh_o[idx_o] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (take_i) ptr_d = CW'(next_core(int'(idx_o), N));
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tmem_crossbar_ctrl.sv
// TMEM crossbar: per-bank RR arbitration, registered bank address, data mux.
// Ports: CLK_I, RST_I, TMEM_CYC/ADR_I, TMEM_GNT/DAT_O, BANK_ADR_O, BANK_DAT_I.
// Option: TMEM_XBAR_PIPELINE_EN lets DATA re-arbitrate straight into ISSUE.
import tmem_crossbar_ctrl_pkg::*;

module tmem_crossbar_ctrl #(
  parameter int NUM_CORES = MAX_CORES,
  parameter int NUM_BANKS = MAX_TMEM_BANKS,
  parameter int BANK_BITS = 2,
  parameter int AW        = WB_WIDTH
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [NUM_CORES-1:0]    TMEM_CYC_I,
  input  logic [NUM_CORES*AW-1:0] TMEM_ADR_I,
  output logic [NUM_CORES-1:0]    TMEM_GNT_O,
  output logic [NUM_CORES*AW-1:0] TMEM_DAT_O,
  output logic [NUM_BANKS*AW-1:0] BANK_ADR_O,
  input  logic [NUM_BANKS*AW-1:0] BANK_DAT_I
);

  localparam int CW = $clog2(NUM_CORES);

  logic [NUM_BANKS-1:0]                data_v;
  logic [NUM_BANKS-1:0][CW-1:0]        win_all;
  logic [NUM_BANKS-1:0][NUM_CORES-1:0] oh_all;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    tmem_xb_state_e       state_q, state_d;
    logic [CW-1:0]        win_q, win_d;
    logic [NUM_CORES-1:0] oh_q, oh_d;
    logic [AW-1:0]        adr_q, adr_d;
    logic [NUM_CORES-1:0] req, mask, oh;
    logic [CW-1:0]        idx;
    logic                 any, take;

    always_comb begin
      req = '0;
      for (int c = 0; c < NUM_CORES; c++)
        req[c] = TMEM_CYC_I[c] &&
          (TMEM_ADR_I[c*AW +: BANK_BITS] == BANK_BITS'(b));
    end

`ifdef TMEM_XBAR_PIPELINE_EN
    // The core just granted still holds its old request this cycle.
    assign mask = (state_q == TMEM_XB_DATA) ? oh_q : '0;
`else
    assign mask = '0;
`endif

    tmem_rr_arbiter #(.N(NUM_CORES), .CW(CW)) u_arb (
      .clk    (CLK_I),
      .rst    (RST_I),
      .req_i  (req),
      .mask_i (mask),
      .take_i (take),
      .any_o  (any),
      .idx_o  (idx),
      .oh_o   (oh)
    );

    always_comb begin
      state_d = state_q;
      win_d   = win_q;
      oh_d    = oh_q;
      adr_d   = adr_q;
      take    = 1'b0;
      unique case (state_q)
        TMEM_XB_IDLE:  take = any;
        TMEM_XB_ISSUE: state_d = TMEM_XB_DATA;
        TMEM_XB_DATA: begin
`ifdef TMEM_XBAR_PIPELINE_EN
          take    = any;
`endif
          state_d = TMEM_XB_IDLE;
        end
        default: state_d = TMEM_XB_IDLE;
      endcase
      if (take) begin
        win_d   = idx;
        oh_d    = oh;
        adr_d   = TMEM_ADR_I[int'(idx)*AW +: AW] >> BANK_BITS;
        state_d = TMEM_XB_ISSUE;
      end
    end

    always_ff @(posedge CLK_I) begin
      if (RST_I) begin
        state_q <= TMEM_XB_IDLE;
        win_q   <= '0;
        oh_q    <= '0;
        adr_q   <= '0;
      end else begin
        state_q <= state_d;
        win_q   <= win_d;
        oh_q    <= oh_d;
        adr_q   <= adr_d;
      end
    end

    assign BANK_ADR_O[b*AW +: AW] = adr_q;
    assign data_v[b]  = (state_q == TMEM_XB_DATA);
    assign win_all[b] = win_q;
    assign oh_all[b]  = oh_q;
  end

  always_comb begin
    TMEM_GNT_O = '0;
    TMEM_DAT_O = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (data_v[b]) begin
        TMEM_GNT_O = TMEM_GNT_O | oh_all[b];
        TMEM_DAT_O[int'(win_all[b])*AW +: AW] =
          TMEM_DAT_O[int'(win_all[b])*AW +: AW] | BANK_DAT_I[b*AW +: AW];
      end
    end
  end

endmodule

// File: tb/tb_tmem_crossbar_ctrl.sv
// Self-checking bench for tmem_crossbar_ctrl: directed plan plus random cores.
// Reference is a cycle-count slot model per bank with round-robin pointers.
module tb_tmem_crossbar_ctrl;

  localparam int NC = 4;
  localparam int NB = 4;
  localparam int AW = 32;
`ifdef TMEM_XBAR_PIPELINE_EN
  localparam int SLOT = 2;
`else
  localparam int SLOT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    cyc = '0;
  logic [NC*AW-1:0] adr = '0;
  logic [NC-1:0]    gnt;
  logic [NC*AW-1:0] dat;
  logic [NB*AW-1:0] badr;
  logic [NB*AW-1:0] bdat = '0;

  tmem_crossbar_ctrl dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .TMEM_CYC_I (cyc),
    .TMEM_ADR_I (adr),
    .TMEM_GNT_O (gnt),
    .TMEM_DAT_O (dat),
    .BANK_ADR_O (badr),
    .BANK_DAT_I (bdat)
  );

  always #5 clk = ~clk;

  int          ovr_bank = -1;
  logic [31:0] ovr_val  = '0;

  function automatic logic [31:0] mem_fn(input int b, input logic [31:0] a);
    if (b == ovr_bank) return ovr_val;
    return (a * 32'h9E37_79B1) ^ (32'(b) << 28) ^ 32'h5A5A_0000;
  endfunction

  // Bank memories: registered read, data one cycle after address.
  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      bdat[b*AW +: AW] <= mem_fn(b, badr[b*AW +: AW]);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: each bank looks at requests on edge nxt; a winner
  // is granted one edge later and the bank looks again SLOT edges later.
  int          edge_n = 0;
  int          nxt   [NB];
  int          ptr   [NB];
  int          excl  [NB];
  int          g_at  [NB];
  int          g_core[NB];
  logic [31:0] a_exp [NB];
  logic [NC-1:0] exp_gnt;
  logic [31:0]   exp_dat[NC];

  initial
    for (int b = 0; b < NB; b++) begin
      nxt[b] = 0; ptr[b] = 0; excl[b] = -1;
      g_at[b] = -1; g_core[b] = 0; a_exp[b] = '0;
    end

  task automatic tick();
    logic [NC-1:0]    c_s;
    logic [NC*AW-1:0] a_s;
    logic             r_s;
    int               w, c;
    c_s = cyc; a_s = adr; r_s = rst;
    @(posedge clk);
    edge_n++;
    for (int b = 0; b < NB; b++) begin
      if (r_s) begin
        nxt[b] = edge_n + 1; ptr[b] = 0; excl[b] = -1;
        g_at[b] = -1; a_exp[b] = '0;
      end else if (edge_n >= nxt[b]) begin
        w = -1;
        for (int k = 0; k < NC; k++) begin
          c = (ptr[b] + k) % NC;
          if (w < 0 && c != excl[b] && c_s[c] &&
              int'(a_s[c*AW +: 2]) == b) w = c;
        end
        if (w >= 0) begin
          ptr[b]    = (w + 1) % NC;
          g_at[b]   = edge_n + 1;
          g_core[b] = w;
          a_exp[b]  = a_s[w*AW +: AW] >> 2;
          nxt[b]    = edge_n + SLOT;
          excl[b]   = (SLOT == 2) ? w : -1;
        end else begin
          nxt[b]  = edge_n + 1;
          excl[b] = -1;
        end
      end
    end
    #1;
    exp_gnt = '0;
    for (int i = 0; i < NC; i++) exp_dat[i] = '0;
    for (int b = 0; b < NB; b++)
      if (g_at[b] == edge_n) begin
        exp_gnt[g_core[b]] = 1'b1;
        exp_dat[g_core[b]] = exp_dat[g_core[b]] | mem_fn(b, a_exp[b]);
      end
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    for (int i = 0; i < NC; i++)
      chk($sformatf("dat%0d", i), dat[i*AW +: AW], exp_dat[i]);
    for (int b = 0; b < NB; b++)
      chk($sformatf("badr%0d", b), badr[b*AW +: AW], a_exp[b]);
  endtask

  task automatic set_req(input int c, input logic [31:0] a);
    cyc[c] = 1'b1;
    adr[c*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = '0; adr = '0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_dat", 32'(|dat), 32'h0);
    chk("rst_badr", 32'(|badr), 32'h0);
    tick();
    rst = 1'b0;
  endtask

  int ord[$];
  int gap[$];
  int prev, first_t, found;
  int ph[NC];

  initial begin
    // Single read with forced bank 2 data.
    do_reset();
    ovr_bank = 2; ovr_val = 32'h0000_CAFE;
    set_req(1, 32'h0000_0006);
    tick();
    chk("sr_adr", badr[2*AW +: AW], 32'h1);
    chk("sr_nognt", 32'(gnt), 32'h0);
    tick();
    chk("sr_gnt", 32'(gnt), 32'h2);
    chk("sr_dat", dat[1*AW +: AW], 32'h0000_CAFE);
    cyc[1] = 1'b0;
    tick();
    chk("sr_gnt_off", 32'(gnt), 32'h0);
    ovr_bank = -1;

    // Four-way conflict on bank 0.
    do_reset();
    for (int c = 0; c < NC; c++) set_req(c, 32'((c + 1) << 2));
    ord.delete(); gap.delete(); prev = -1; first_t = -1;
    for (int t = 0; t < 40 && ord.size() < 4; t++) begin
      tick();
      for (int c = 0; c < NC; c++)
        if (gnt[c]) begin
          ord.push_back(c);
          if (prev >= 0) gap.push_back(t - prev);
          else first_t = t;
          prev = t;
          cyc[c] = 1'b0;
        end
    end
    chk("conf_cnt", 32'(ord.size()), 32'd4);
    chk("conf_lat", 32'(first_t), 32'd1);
    foreach (ord[i]) chk($sformatf("conf_ord%0d", i), 32'(ord[i]), 32'(i));
    foreach (gap[i]) chk($sformatf("conf_gap%0d", i), 32'(gap[i]), 32'(SLOT));
    cyc = '0;
    tick();

    // Parallel banks.
    do_reset();
    for (int c = 0; c < NC; c++) set_req(c, 32'(((c + 8) << 2) | (3 - c)));
    tick();
    chk("par_nognt", 32'(gnt), 32'h0);
    chk("par_adr0", badr[0*AW +: AW], 32'd11);
    tick();
    chk("par_gnt", 32'(gnt), 32'hF);
    cyc = '0;
    tick();
    chk("par_off", 32'(gnt), 32'h0);

    // Fairness: cores 0 and 2 keep hammering bank 1.
    do_reset();
    ph[0] = 5; ph[2] = 9;
    set_req(0, 32'((ph[0] << 2) | 1));
    set_req(2, 32'((ph[2] << 2) | 1));
    ord.delete();
    for (int t = 0; t < 40 && ord.size() < 4; t++) begin
      tick();
      for (int c = 0; c < NC; c += 2)
        if (gnt[c]) begin
          ord.push_back(c);
          ph[c]++;
          set_req(c, 32'((ph[c] << 2) | 1));
        end
    end
    chk("fair_cnt", 32'(ord.size()), 32'd4);
    foreach (ord[i])
      chk($sformatf("fair_ord%0d", i), 32'(ord[i]), 32'((i % 2) * 2));
    cyc = '0;
    tick(); tick(); tick();

    // Reset while bank 0 is in ISSUE.
    do_reset();
    set_req(0, 32'h0000_0040);
    tick();
    chk("mr_issue", badr[0 +: AW], 32'h10);
    rst = 1'b1;
    tick();
    chk("mr_gnt", 32'(gnt), 32'h0);
    chk("mr_dat", 32'(|dat), 32'h0);
    chk("mr_badr", 32'(|badr), 32'h0);
    rst = 1'b0;
    tick();
    chk("mr_gnt1", 32'(gnt), 32'h0);
    tick();
    chk("mr_gnt2", 32'(gnt), 32'h1);
    cyc = '0;
    tick();

    // Dropped request on bank 2.
    do_reset();
    set_req(3, 32'h0000_002A);
    tick();
    cyc[3] = 1'b0;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h8);
    set_req(3, 32'h0000_0016);
    found = 0;
    for (int t = 0; t < 10 && found == 0; t++) begin
      tick();
      if (gnt[3]) found = 1;
    end
    chk("drop_next", 32'(found), 32'd1);
    chk("drop_adr", badr[2*AW +: AW], 32'h5);
    cyc = '0;
    tick();

    // Random cores obeying the hold-until-grant rule.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      tick();
      for (int c = 0; c < NC; c++) begin
        if (cyc[c] && exp_gnt[c]) begin
          if ($urandom_range(0, 1) == 0) cyc[c] = 1'b0;
          else set_req(c, $urandom_range(0, 1023));
        end else if (!cyc[c] && $urandom_range(0, 2) == 0) begin
          set_req(c, $urandom_range(0, 1023));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
